fltr_multi: RTL

FLTR_MULTI -- requirements
Module: fltr_multi

---
 rtl/fltr_multi_if.sv | 15 +
 rtl/fltr_multi.sv | 96 +++++++++
 2 files changed

// File: rtl/fltr_multi_if.sv
// Bundle of control, sample and result signals for the multi-channel level filter.
interface fltr_multi_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 4
);
  logic             en;
  logic [CNT_W-1:0] thr;
  logic [CH-1:0]    in;
  logic [CH-1:0]    out;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;

  modport master (output en, thr, in, input out, rise, fall);
  modport slave  (input en, thr, in, output out, rise, fall);
endinterface

// File: rtl/fltr_multi.sv
// Multi-channel debounce filter: a channel's output follows its synchronised
// input only after the input has disagreed with it for T consecutive enabled
// cycles, with registered rise/fall pulses on each change.
module fltr_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input logic        clk,
  input logic        reset,
  fltr_multi_if.slave bus
);

  typedef enum logic {ST_STABLE, ST_PENDING} ch_st_e;

  logic [CH-1:0]    samp;
  logic [CNT_W-1:0] thr_m1;
  logic [CH-1:0]    out_q, out_d;
  logic [CH-1:0]    rise_q, rise_d;
  logic [CH-1:0]    fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  ch_st_e           st_c  [CH];

  // Input synchroniser; frozen while disabled, bypassed when no stages.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign samp = bus.in;
    end else begin : g_sync
      logic [CH-1:0] sync_q [SYNC_STAGES];

      // Shift raw inputs through the synchroniser chain.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= {CH{RESET_VAL}};
        end else if (bus.en) begin
          sync_q[0] <= bus.in;
          for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign samp = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Effective threshold minus one; thr of zero behaves as one.
  assign thr_m1 = ((bus.thr == '0) ? CNT_W'(1) : bus.thr) - CNT_W'(1);

  // Per-channel next state: count disagreement, flip once the run reaches T.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(CH); i++) begin
      st_c[i] = (samp[i] == out_q[i]) ? ST_STABLE : ST_PENDING;
      if (bus.en) begin
        case (st_c[i])
          ST_STABLE: cnt_d[i] = '0;
          ST_PENDING: begin
            if (cnt_q[i] >= thr_m1) begin
              out_d[i]  = samp[i];
              cnt_d[i]  = '0;
              rise_d[i] = samp[i];
              fall_d[i] = ~samp[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: cnt_d[i] = '0;
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= {CH{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < int'(CH); i++) cnt_q[i] <= '0;
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule
